// File: rtl/ysyx_22050550_lsu_stage.sv
// Load/store stage between EXU and WBU of the ysyx_22050550 RV64 core.
// Latches one EX instruction, performs at most one outstanding access on a
// valid/ready memory port, aligns/extends load data and presents the result
// to the write-back unit as the io_LSWB_* bundle.
// Ports:
//   clock, reset            core clock, asynchronous active-low reset
//   ex_*                    instruction from EXU (ex_valid/ex_ready handshake)
//   mem_req_*, mem_addr,
//   mem_wen/wdata/wstrb     memory request channel (held stable until ready)
//   mem_resp_valid/rdata    memory response channel (stores respond too)
//   io_LSWB_*               bundle to WBU, held while io_LSWB_valid is high
//   io_ReadyWB_ready        WBU accepts the bundle
module ysyx_22050550_lsu_stage #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [63:0] ex_pc,
   input  logic [63:0] ex_alures,
   input  logic [31:0] ex_inst,
   input  logic [63:0] ex_rs2,
   input  logic        ex_readflag,
   input  logic        ex_writeflag,
   input  logic [2:0]  ex_func3,
   input  logic [4:0]  ex_waddr,
   input  logic        ex_wen,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wstrb,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_rdata,
   output logic        io_LSWB_valid,
   output logic [63:0] io_LSWB_pc,
   output logic [63:0] io_LSWB_alures,
   output logic [63:0] io_LSWB_lsures,
   output logic [31:0] io_LSWB_inst,
   output logic        io_LSWB_readflag,
   output logic        io_LSWB_wen,
   output logic        io_LSWB_abort,
   output logic [4:0]  io_LSWB_waddr,
   output logic [2:0]  io_LSWB_func3,
   input  logic        io_ReadyWB_ready
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               mem_op;
   logic               misaligned;
   logic               bad_op;
   logic [2:0]         off;
   logic [7:0]         strb_base;
   logic [15:0]        strb_wide;
   logic [63:0]        wdata_shift;

   // Sign/zero extension of the lane-aligned read data
   function automatic logic [63:0] load_ext(input logic [63:0] raw,
                                            input logic [2:0]  lane,
                                            input logic [2:0]  f3);
      logic [63:0] d;
      d = raw >> {lane, 3'b000};
      case (f3)
         3'b000:  load_ext = {{56{d[7]}},  d[7:0]};
         3'b001:  load_ext = {{48{d[15]}}, d[15:0]};
         3'b010:  load_ext = {{32{d[31]}}, d[31:0]};
         3'b100:  load_ext = {56'd0, d[7:0]};
         3'b101:  load_ext = {48'd0, d[15:0]};
         3'b110:  load_ext = {32'd0, d[31:0]};
         default: load_ext = d;
      endcase
   endfunction

   // Reset gates ex_ready so nothing is offered upstream while held in reset
   assign ex_ready = reset & ((state == IDLE) | ((state == OUT) & io_ReadyWB_ready));
   assign accept   = ex_valid & ex_ready;

   // Decode of the incoming instruction: alignment check and lane placement
   always_comb begin
      off         = ex_alures[2:0];
      mem_op      = ex_readflag | ex_writeflag;
      misaligned  = 1'b0;
      strb_base   = 8'h01;
      case (ex_func3[1:0])
         2'd0: strb_base = 8'h01;
         2'd1: begin strb_base = 8'h03; misaligned = off[0];      end
         2'd2: begin strb_base = 8'h0F; misaligned = |off[1:0];   end
         default: begin strb_base = 8'hFF; misaligned = |off;     end
      endcase
      bad_op      = mem_op & (misaligned | (ex_func3 == 3'b111));
      strb_wide   = 16'(strb_base) << off;
      wdata_shift = ex_rs2 << {off, 3'b000};
   end

   // Stage FSM; all outputs except ex_ready are registered here
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         cnt              <= '0;
         mem_req_valid    <= 1'b0;
         mem_addr         <= 64'd0;
         mem_wen          <= 1'b0;
         mem_wdata        <= 64'd0;
         mem_wstrb        <= 8'd0;
         io_LSWB_valid    <= 1'b0;
         io_LSWB_pc       <= 64'd0;
         io_LSWB_alures   <= 64'd0;
         io_LSWB_lsures   <= 64'd0;
         io_LSWB_inst     <= 32'd0;
         io_LSWB_readflag <= 1'b0;
         io_LSWB_wen      <= 1'b0;
         io_LSWB_abort    <= 1'b0;
         io_LSWB_waddr    <= 5'd0;
         io_LSWB_func3    <= 3'd0;
      end else begin
         case (state)
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  cnt           <= '0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  io_LSWB_lsures <= io_LSWB_readflag
                                    ? load_ext(mem_rdata, io_LSWB_alures[2:0], io_LSWB_func3)
                                    : 64'd0;
                  io_LSWB_valid  <= 1'b1;
                  state          <= OUT;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  io_LSWB_abort  <= 1'b1;
                  io_LSWB_wen    <= 1'b0;
                  io_LSWB_lsures <= 64'd0;
                  io_LSWB_valid  <= 1'b1;
                  state          <= OUT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            OUT: begin
               if (io_ReadyWB_ready) begin
                  io_LSWB_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: ;
         endcase

         // A new accept (also back-to-back from OUT) overrides the above
         if (accept) begin
            io_LSWB_pc       <= ex_pc;
            io_LSWB_alures   <= ex_alures;
            io_LSWB_inst     <= ex_inst;
            io_LSWB_readflag <= ex_readflag;
            io_LSWB_waddr    <= ex_waddr;
            io_LSWB_func3    <= ex_func3;
            io_LSWB_lsures   <= 64'd0;
            io_LSWB_abort    <= bad_op;
            io_LSWB_wen      <= ex_wen & ~bad_op;
            mem_addr         <= {ex_alures[63:3], 3'b000};
            mem_wen          <= ex_writeflag;
            mem_wdata        <= wdata_shift;
            mem_wstrb        <= strb_wide[7:0];
            if (mem_op && !bad_op) begin
               mem_req_valid <= 1'b1;
               io_LSWB_valid <= 1'b0;
               state         <= REQ;
            end else begin
               mem_req_valid <= 1'b0;
               io_LSWB_valid <= 1'b1;
               state         <= OUT;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22050550_lsu_stage.sv
// Directed bench for ysyx_22050550_lsu_stage with an expected-bundle queue.
module tb_ysyx_22050550_lsu_stage;

   localparam int unsigned TIMEOUT = 256;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready;
   logic [63:0] ex_pc, ex_alures, ex_rs2;
   logic [31:0] ex_inst;
   logic        ex_readflag, ex_writeflag, ex_wen;
   logic [2:0]  ex_func3;
   logic [4:0]  ex_waddr;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wstrb;
   logic        io_LSWB_valid, io_LSWB_readflag, io_LSWB_wen, io_LSWB_abort;
   logic [63:0] io_LSWB_pc, io_LSWB_alures, io_LSWB_lsures;
   logic [31:0] io_LSWB_inst;
   logic [4:0]  io_LSWB_waddr;
   logic [2:0]  io_LSWB_func3;
   logic        io_ReadyWB_ready;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] alures;
      logic [63:0] lsures;
      logic [31:0] inst;
      logic        readflag;
      logic        wen;
      logic        abort;
      logic [4:0]  waddr;
      logic [2:0]  func3;
   } bundle_t;

   bundle_t exp_q[$];
   int      n_tests = 0;
   int      n_fail  = 0;

   ysyx_22050550_lsu_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_pc(ex_pc), .ex_alures(ex_alures), .ex_inst(ex_inst), .ex_rs2(ex_rs2),
      .ex_readflag(ex_readflag), .ex_writeflag(ex_writeflag), .ex_func3(ex_func3),
      .ex_waddr(ex_waddr), .ex_wen(ex_wen),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .io_LSWB_valid(io_LSWB_valid), .io_LSWB_pc(io_LSWB_pc),
      .io_LSWB_alures(io_LSWB_alures), .io_LSWB_lsures(io_LSWB_lsures),
      .io_LSWB_inst(io_LSWB_inst), .io_LSWB_readflag(io_LSWB_readflag),
      .io_LSWB_wen(io_LSWB_wen), .io_LSWB_abort(io_LSWB_abort),
      .io_LSWB_waddr(io_LSWB_waddr), .io_LSWB_func3(io_LSWB_func3),
      .io_ReadyWB_ready(io_ReadyWB_ready)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive an EX instruction and optionally record its expected bundle
   task automatic present(input bit push, input logic [63:0] pc, input logic [63:0] alu,
                          input logic [63:0] rs2, input logic [31:0] inst,
                          input logic rf, input logic wf, input logic [2:0] f3,
                          input logic [4:0] rd, input logic wen,
                          input logic [63:0] exp_ls, input logic exp_ab);
      bundle_t b;
      ex_pc = pc; ex_alures = alu; ex_rs2 = rs2; ex_inst = inst;
      ex_readflag = rf; ex_writeflag = wf; ex_func3 = f3;
      ex_waddr = rd; ex_wen = wen; ex_valid = 1'b1;
      b.pc = pc; b.alures = alu; b.lsures = exp_ls; b.inst = inst;
      b.readflag = rf; b.wen = wen & ~exp_ab; b.abort = exp_ab;
      b.waddr = rd; b.func3 = f3;
      if (push) exp_q.push_back(b);
   endtask

   task automatic issue(input logic [63:0] pc, input logic [63:0] alu,
                        input logic [63:0] rs2, input logic [31:0] inst,
                        input logic rf, input logic wf, input logic [2:0] f3,
                        input logic [4:0] rd, input logic wen,
                        input logic [63:0] exp_ls, input logic exp_ab);
      present(1'b1, pc, alu, rs2, inst, rf, wf, f3, rd, wen, exp_ls, exp_ab);
      tick();
      ex_valid = 1'b0;
   endtask

   // Compare the presented bundle against the oldest expectation
   task automatic check_bundle(input string tag);
      bundle_t b;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(io_LSWB_valid), 64'd0);
         return;
      end
      b = exp_q.pop_front();
      chk({tag, "_valid"},    64'(io_LSWB_valid),    64'd1);
      chk({tag, "_pc"},       io_LSWB_pc,            b.pc);
      chk({tag, "_alures"},   io_LSWB_alures,        b.alures);
      chk({tag, "_lsures"},   io_LSWB_lsures,        b.lsures);
      chk({tag, "_inst"},     64'(io_LSWB_inst),     64'(b.inst));
      chk({tag, "_readflag"}, 64'(io_LSWB_readflag), 64'(b.readflag));
      chk({tag, "_wen"},      64'(io_LSWB_wen),      64'(b.wen));
      chk({tag, "_abort"},    64'(io_LSWB_abort),    64'(b.abort));
      chk({tag, "_waddr"},    64'(io_LSWB_waddr),    64'(b.waddr));
      chk({tag, "_func3"},    64'(io_LSWB_func3),    64'(b.func3));
   endtask

   // Serve an issued access with ready/response in consecutive cycles
   task automatic mem_direct(input string tag, input logic [63:0] eaddr, input logic ewen,
                             input logic [63:0] ewdata, input logic [7:0] estrb,
                             input logic [63:0] rdata);
      chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, "_addr"},      mem_addr,            eaddr);
      chk({tag, "_mem_wen"},   64'(mem_wen),        64'(ewen));
      if (ewen) begin
         chk({tag, "_wdata"}, mem_wdata,        ewdata);
         chk({tag, "_wstrb"}, 64'(mem_wstrb),   64'(estrb));
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      chk({tag, "_req_drop"}, 64'(mem_req_valid), 64'd0);
      chk({tag, "_no_early"}, 64'(io_LSWB_valid), 64'd0);
      mem_resp_valid = 1'b1;
      mem_rdata      = rdata;
      tick();
      mem_resp_valid = 1'b0;
      check_bundle(tag);
   endtask

   initial begin
      int waited;
      bit got;
      reset = 1'b0;
      ex_valid = 1'b0; ex_pc = '0; ex_alures = '0; ex_rs2 = '0; ex_inst = '0;
      ex_readflag = 1'b0; ex_writeflag = 1'b0; ex_func3 = '0; ex_waddr = '0; ex_wen = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      io_ReadyWB_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_lswb_valid", 64'(io_LSWB_valid), 64'd0);
      chk("rst_req_valid",  64'(mem_req_valid), 64'd0);
      chk("rst_ex_ready",   64'(ex_ready),      64'd0);
      chk("rst_lsures",     io_LSWB_lsures,     64'd0);
      chk("rst_wstrb",      64'(mem_wstrb),     64'd0);
      reset = 1'b1;
      tick();
      chk("idle_ex_ready", 64'(ex_ready), 64'd1);

      // ALU pass-through, one cycle latency, no memory request
      issue(64'h80000000, 64'h1234, 64'h0, 32'h00000013, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1,
            64'd0, 1'b0);
      chk("alu_no_req", 64'(mem_req_valid), 64'd0);
      check_bundle("alu");
      tick();
      chk("alu_back_idle", 64'(io_LSWB_valid), 64'd0);

      // LB / LBU at byte lane 3
      issue(64'h80000004, 64'h80000003, 64'h0, 32'h00300083, 1'b1, 1'b0, 3'b000, 5'd10, 1'b1,
            64'hFFFFFFFFFFFFFF80, 1'b0);
      mem_direct("lb", 64'h80000000, 1'b0, 64'h0, 8'h0, 64'h0000000080000000);
      issue(64'h80000008, 64'h80000003, 64'h0, 32'h00304083, 1'b1, 1'b0, 3'b100, 5'd11, 1'b1,
            64'h80, 1'b0);
      mem_direct("lbu", 64'h80000000, 1'b0, 64'h0, 8'h0, 64'h0000000080000000);

      // LW / LWU at upper word lane
      issue(64'h8000000C, 64'h80000004, 64'h0, 32'h00402083, 1'b1, 1'b0, 3'b010, 5'd12, 1'b1,
            64'hFFFFFFFF87654321, 1'b0);
      mem_direct("lw", 64'h80000000, 1'b0, 64'h0, 8'h0, 64'h8765432100000000);
      issue(64'h80000010, 64'h80000004, 64'h0, 32'h00406083, 1'b1, 1'b0, 3'b110, 5'd13, 1'b1,
            64'h0000000087654321, 1'b0);
      mem_direct("lwu", 64'h80000000, 1'b0, 64'h0, 8'h0, 64'h8765432100000000);

      // LH sign-extension at lane 2
      issue(64'h80000014, 64'h8000000A, 64'h0, 32'h00A01083, 1'b1, 1'b0, 3'b001, 5'd14, 1'b1,
            64'hFFFFFFFFFFFF9ABC, 1'b0);
      mem_direct("lh", 64'h80000008, 1'b0, 64'h0, 8'h0, 64'h000000009ABC0000);

      // SH in the top halfword lane
      issue(64'h80000018, 64'h80000006, 64'hABCD, 32'h00B01323, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0,
            64'd0, 1'b0);
      mem_direct("sh", 64'h80000000, 1'b1, 64'hABCD000000000000, 8'hC0, 64'hDEADBEEFDEADBEEF);

      // Misaligned LW aborts without touching memory
      issue(64'h8000001C, 64'h80000002, 64'h0, 32'h00202083, 1'b1, 1'b0, 3'b010, 5'd15, 1'b1,
            64'd0, 1'b1);
      chk("lw_mis_no_req", 64'(mem_req_valid), 64'd0);
      check_bundle("lw_mis");

      // func3=111 on a load aborts
      issue(64'h80000020, 64'h80000008, 64'h0, 32'h00807083, 1'b1, 1'b0, 3'b111, 5'd16, 1'b1,
            64'd0, 1'b1);
      chk("f3_7_no_req", 64'(mem_req_valid), 64'd0);
      check_bundle("f3_7");
      tick();

      // Stalls on both sides, then back-to-back accept on the WB handshake
      io_ReadyWB_ready = 1'b0;
      present(1'b1, 64'h80000024, 64'h80000010, 64'h0, 32'h01003383, 1'b1, 1'b0, 3'b011,
              5'd7, 1'b1, 64'h1122334455667788, 1'b0);
      tick();
      present(1'b1, 64'h80000028, 64'h55, 64'h0, 32'h05500493, 1'b0, 1'b0, 3'b000,
              5'd9, 1'b1, 64'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
         chk("stall_req_addr",  mem_addr,            64'h80000010);
         chk("stall_ex_ready",  64'(ex_ready),       64'd0);
         tick();
      end
      mem_req_ready = 1'b1;
      chk("stall_req_still", 64'(mem_req_valid), 64'd1);
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'h1122334455667788;
      tick();
      mem_resp_valid = 1'b0;
      mem_rdata      = 64'h0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wbstall_valid",    64'(io_LSWB_valid), 64'd1);
         chk("wbstall_lsures",   io_LSWB_lsures,     64'h1122334455667788);
         chk("wbstall_ex_ready", 64'(ex_ready),      64'd0);
         tick();
      end
      io_ReadyWB_ready = 1'b1;
      #1;
      chk("hs_ex_ready", 64'(ex_ready), 64'd1);
      check_bundle("ld_stalled");
      tick();
      ex_valid = 1'b0;
      check_bundle("b2b_alu");
      tick();
      chk("b2b_idle", 64'(io_LSWB_valid), 64'd0);

      // Timeout: request accepted, no response ever
      issue(64'h8000002C, 64'h80000018, 64'h0, 32'h01803403, 1'b1, 1'b0, 3'b011, 5'd8, 1'b1,
            64'd0, 1'b1);
      chk("to_req_valid", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      waited = 0;
      got    = 1'b0;
      for (int i = 1; i <= TIMEOUT + 40 && !got; i++) begin
         tick();
         if (io_LSWB_valid) begin
            got    = 1'b1;
            waited = i;
         end
      end
      chk("to_latency", 64'(waited), 64'(TIMEOUT));
      if (got) check_bundle("timeout");
      else void'(exp_q.pop_front());
      tick();

      // Reset while in WAIT, then a stray response in IDLE
      present(1'b0, 64'h80000030, 64'h80000020, 64'h0, 32'h02003403, 1'b1, 1'b0, 3'b011,
              5'd4, 1'b1, 64'd0, 1'b0);
      tick();
      ex_valid      = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      reset         = 1'b0;
      #1;
      chk("wrst_lswb_valid", 64'(io_LSWB_valid), 64'd0);
      chk("wrst_req_valid",  64'(mem_req_valid), 64'd0);
      chk("wrst_addr",       mem_addr,           64'd0);
      chk("wrst_pc",         io_LSWB_pc,         64'd0);
      tick();
      reset          = 1'b1;
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'hFFFFFFFFFFFFFFFF;
      tick();
      mem_resp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_resp_no_bundle", 64'(io_LSWB_valid), 64'd0);
         chk("late_resp_lsures",    io_LSWB_lsures,     64'd0);
         tick();
      end
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
